// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned INST_WIDTH = 32;
    localparam int unsigned PC_STEP    = 4;
    localparam logic [INST_WIDTH-1:0] HALT_WORD = 32'h0000_0000;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t BOOT   = 2'd0;
    localparam fetch_state_t RUN    = 2'd1;
    localparam fetch_state_t HALTED = 2'd2;

endpackage

// File: rtl/fetch_unit32_if_id_reg.sv
// Single-entry IF/ID holding register with valid/ready handshake and flush.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int unsigned INST_W = INST_WIDTH,
    parameter int unsigned PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              capture,
    input  logic [INST_W-1:0] capture_inst,
    input  logic [PC_W-1:0]   capture_pc,
    input  logic              id_ready,
    output logic [INST_W-1:0] id_inst,
    output logic [PC_W-1:0]   id_pc,
    output logic              id_valid
);

    // Flush wins; a capture refills; otherwise a consumed entry drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_inst  <= '0;
            id_pc    <= '0;
            id_valid <= 1'b0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (capture) begin
            id_inst  <= capture_inst;
            id_pc    <= capture_pc;
            id_valid <= 1'b1;
        end else if (id_ready) begin
            id_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit32.sv
// Instruction-fetch stage: owns the PC, drives the ROM, fills IF/ID.
// Optional macro FETCH_MISALIGN_TRAP_EN traps misaligned redirect targets.
module fetch_unit32
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_inst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic            halted,
    output logic [31:0]     fetch_count
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            misalign_fault
`endif
);

    localparam int unsigned CNT_W = 32;

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic            load_c;
    logic            capture_c;
    logic            flush_c;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            fault_next;
`endif

    assign imem_addr = pc;

    // Next-state, next-PC and IF/ID control; redirect overrides everything.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        capture_c  = 1'b0;
        flush_c    = 1'b0;
        load_c     = !id_valid || id_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_next = misalign_fault;
`endif
        if (redirect_valid) begin
            flush_c    = 1'b1;
            state_next = RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
            pc_next = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                fault_next = 1'b1;
                state_next = HALTED;
            end
`else
            pc_next = redirect_pc & ~XLEN'(3);
`endif
        end else begin
            case (state)
                BOOT:   state_next = RUN;
                RUN: begin
                    if (load_c) begin
                        if (imem_inst == XLEN'(HALT_WORD)) begin
                            state_next = HALTED;
                        end else begin
                            capture_c = 1'b1;
                            pc_next   = pc + XLEN'(PC_STEP);
                        end
                    end
                end
                HALTED: state_next = HALTED;
                default: state_next = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            halted      <= 1'b0;
            fetch_count <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_fault <= 1'b0;
`endif
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            halted <= (state_next == HALTED);
            // A transfer counts even when a redirect flushes the same cycle.
            if (id_valid && id_ready) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_fault <= fault_next;
`endif
        end
    end

    if_id_reg #(
        .INST_W (XLEN),
        .PC_W   (XLEN)
    ) u_if_id (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush_c),
        .capture      (capture_c),
        .capture_inst (imem_inst),
        .capture_pc   (pc),
        .id_ready     (id_ready),
        .id_inst      (id_inst),
        .id_pc        (id_pc),
        .id_valid     (id_valid)
    );

endmodule

// File: tb/tb_fetch_unit32.sv
// Directed bench for fetch_unit32 with a ROM model and an in-order scoreboard.
module tb_fetch_unit32;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        id_ready;
    logic        halted;
    logic [31:0] fetch_count;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_fault;
`endif

    logic [31:0] rom [1024];
    exp_t        sb [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;

    assign imem_inst = rom[imem_addr[11:2]];

    fetch_unit32 dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .halted         (halted),
        .fetch_count    (fetch_count)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_fault (misalign_fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = rom[pc[11:2]];
        sb.push_back(e);
    endtask

    // Score the entry about to transfer, then advance one clock.
    task automatic tick();
        exp_t e;
        if (id_valid && id_ready) begin
            n_checks++;
            assert (sb.size() != 0) n_pass++;
            else begin
                n_fail++;
                $error("FAIL sb_underflow: observed=pc %h expected=no transfer", id_pc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_id_pc", id_pc, e.pc);
                check("sb_id_inst", id_inst, e.inst);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_halt(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (halted) break;
            tick();
        end
        check("halt_reached", 32'(halted), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        sb.delete();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fetch_count", fetch_count, 32'd0);
        check("rst_imem_addr", imem_addr, 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 32'h0;
        rom[0]    = 32'h0000_0013;
        rom[1]    = 32'h0050_0513;
        rom[2]    = 32'h0040_0793;
        rom[3]    = 32'h40F5_0533;
        rom[4]    = 32'h00A7_F833;
        rom[5]    = 32'h00A7_F033;
        rom[1023] = 32'h0010_0093;

        // Full program streamed with decode always ready.
        do_reset();
        check("rst_id_inst", id_inst, 32'h0);
        check("rst_id_pc", id_pc, 32'h0);
        for (int a = 0; a < 24; a += 4) push_exp(32'(a));
        id_ready = 1'b1;
        tick();
        check("boot_no_load", 32'(id_valid), 32'd0);
        check("boot_ready_ignored", fetch_count, 32'd0);
        run_to_halt(20);
        check("prog_count", fetch_count, 32'd6);
        check("prog_halt_valid", 32'(id_valid), 32'd0);
        check("prog_halt_pc", imem_addr, 32'h18);

        // Backpressure holds the first entry for three cycles.
        do_reset();
        for (int a = 0; a < 24; a += 4) push_exp(32'(a));
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_valid", 32'(id_valid), 32'd1);
            check("bp_inst", id_inst, 32'h0000_0013);
            check("bp_pc", id_pc, 32'h0);
            check("bp_imem_addr", imem_addr, 32'h4);
        end
        id_ready = 1'b1;
        run_to_halt(20);
        check("bp_count", fetch_count, 32'd6);

        // Redirect while an entry is stalled.
        do_reset();
        tick();
        tick();
        check("rd_pre_valid", 32'(id_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hC;
        tick();
        redirect_valid = 1'b0;
        check("rd_flush", 32'(id_valid), 32'd0);
        check("rd_imem_addr", imem_addr, 32'hC);
        tick();
        check("rd_id_pc", id_pc, 32'hC);
        check("rd_id_inst", id_inst, 32'h40F5_0533);
        push_exp(32'hC);
        push_exp(32'h10);
        push_exp(32'h14);
        id_ready = 1'b1;
        run_to_halt(20);
        check("rd_count", fetch_count, 32'd3);

        // Redirect out of HALTED.
        for (int a = 4; a < 24; a += 4) push_exp(32'(a));
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4;
        tick();
        redirect_valid = 1'b0;
        check("hr_halted", 32'(halted), 32'd0);
        check("hr_valid", 32'(id_valid), 32'd0);
        tick();
        check("hr_id_pc", id_pc, 32'h4);
        check("hr_id_inst", id_inst, 32'h0050_0513);
        run_to_halt(20);
        check("hr_count", fetch_count, 32'd8);

        // PC wraps from the top of the address space.
        push_exp(32'hFFFF_FFFC);
        for (int a = 0; a < 24; a += 4) push_exp(32'(a));
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("wrap_imem_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_next_addr", imem_addr, 32'h0);
        run_to_halt(20);
        check("wrap_count", fetch_count, 32'd15);

        // Asynchronous reset mid-stream.
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("ar_pre_valid", 32'(id_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("ar_valid", 32'(id_valid), 32'd0);
        check("ar_inst", id_inst, 32'h0);
        check("ar_pc", id_pc, 32'h0);
        check("ar_halted", 32'(halted), 32'd0);
        check("ar_count", fetch_count, 32'd0);
        check("ar_imem_addr", imem_addr, 32'h0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("ar_boot_valid", 32'(id_valid), 32'd0);
        tick();
        check("ar_first_valid", 32'(id_valid), 32'd1);
        check("ar_first_pc", id_pc, 32'h0);
        check("ar_first_inst", id_inst, 32'h0000_0013);

        // Misaligned redirect target.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h6;
        tick();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int k = 0; k < 3; k++) begin
            check("mis_fault", 32'(misalign_fault), 32'd1);
            check("mis_halted", 32'(halted), 32'd1);
            check("mis_valid", 32'(id_valid), 32'd0);
            check("mis_pc", imem_addr, 32'h6);
            tick();
        end
        do_reset();
        check("mis_fault_cleared", 32'(misalign_fault), 32'd0);
`else
        check("mis_flush", 32'(id_valid), 32'd0);
        check("mis_aligned_pc", imem_addr, 32'h4);
        tick();
        check("mis_id_pc", id_pc, 32'h4);
        check("mis_id_inst", id_inst, 32'h0050_0513);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
